// File: rtl/ifetch_sram_bridge_if.sv
// ----------------------------------------------------------------------------
// ifetch_sram_bridge_if
//   Bundles the two sides of the instruction-fetch bridge.
//   CPU side : cpu_req, cpu_addr, flush (from IF stage);
//              cpu_inst, cpu_valid, cpu_adel, stall (back to IF stage).
//   SRAM side: sram_req, sram_wr, sram_size, sram_addr (to the bus);
//              sram_addr_ok, sram_data_ok, sram_rdata (from the bus).
//   modport slave  : the bridge itself.
//   modport master : the surrounding environment (IF stage + instruction bus).
// ----------------------------------------------------------------------------
interface ifetch_sram_bridge_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        flush;
    logic [31:0] cpu_inst;
    logic        cpu_valid;
    logic        cpu_adel;
    logic        stall;

    logic        sram_req;
    logic        sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    modport slave (
        input  cpu_req, cpu_addr, flush,
        input  sram_addr_ok, sram_data_ok, sram_rdata,
        output cpu_inst, cpu_valid, cpu_adel, stall,
        output sram_req, sram_wr, sram_size, sram_addr
    );

    modport master (
        output cpu_req, cpu_addr, flush,
        output sram_addr_ok, sram_data_ok, sram_rdata,
        input  cpu_inst, cpu_valid, cpu_adel, stall,
        input  sram_req, sram_wr, sram_size, sram_addr
    );
endinterface

// File: rtl/ifetch_sram_bridge.sv
// ----------------------------------------------------------------------------
// ifetch_sram_bridge
//   Responder end of the instruction-fetch interface. Accepts one fetch at a
//   time, maps the virtual PC to a physical address (kseg0/kseg1 folding when
//   MAP_EN=1), runs a single read on the SRAM-like bus (req/addr_ok/data_ok)
//   and returns the word with a one-cycle cpu_valid pulse.
//
//   Ports:
//     clk     : rising-edge clock
//     resetn  : asynchronous active-low reset
//     bus     : ifetch_sram_bridge_if.slave
//               cpu_req/cpu_addr/flush in, cpu_inst/cpu_valid/cpu_adel/stall out,
//               sram_req/sram_wr/sram_size/sram_addr out,
//               sram_addr_ok/sram_data_ok/sram_rdata in
// ----------------------------------------------------------------------------
module ifetch_sram_bridge #(
    parameter bit MAP_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    ifetch_sram_bridge_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q,     state_d;
    logic        cancel_q,    cancel_d;
    logic        sram_req_q,  sram_req_d;
    logic [31:0] sram_addr_q, sram_addr_d;
    logic [31:0] cpu_inst_q,  cpu_inst_d;
    logic        cpu_adel_q,  cpu_adel_d;

    // kseg0 (0x8xxx_xxxx/0x9xxx_xxxx) and kseg1 (0xAxxx_xxxx/0xBxxx_xxxx)
    // both fold onto the low 512 MB of physical space.
    function automatic logic [31:0] map_addr(input logic [31:0] va);
        if (MAP_EN && (va[31:30] == 2'b10))
            return {3'b000, va[28:0]};
        return va;
    endfunction

    always_comb begin
        state_d     = state_q;
        cancel_d    = cancel_q;
        sram_addr_d = sram_addr_q;
        cpu_inst_d  = cpu_inst_q;
        cpu_adel_d  = cpu_adel_q;

        case (state_q)
            IDLE: begin
                // A redirect in the same cycle makes the current PC stale.
                if (bus.cpu_req && !bus.flush) begin
                    if (bus.cpu_addr[1:0] == 2'b00) begin
                        sram_addr_d = map_addr(bus.cpu_addr);
                        state_d     = ADDR;
                    end else begin
                        cpu_inst_d  = 32'h0;
                        cpu_adel_d  = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            ADDR: begin
                // The bus request cannot be withdrawn; remember to drop the result.
                if (bus.flush)
                    cancel_d = 1'b1;
                if (bus.sram_addr_ok)
                    state_d = DATA;
            end
            DATA: begin
                if (bus.flush)
                    cancel_d = 1'b1;
                if (bus.sram_data_ok) begin
                    cpu_inst_d = bus.sram_rdata;
                    cpu_adel_d = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                cancel_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                cancel_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // Registered request: high exactly while the FSM sits in ADDR.
        sram_req_d = (state_d == ADDR);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cancel_q    <= 1'b0;
            sram_req_q  <= 1'b0;
            sram_addr_q <= 32'h0;
            cpu_inst_q  <= 32'h0;
            cpu_adel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cancel_q    <= cancel_d;
            sram_req_q  <= sram_req_d;
            sram_addr_q <= sram_addr_d;
            cpu_inst_q  <= cpu_inst_d;
            cpu_adel_q  <= cpu_adel_d;
        end
    end

    // A flush arriving in the response cycle also suppresses delivery.
    assign bus.cpu_valid = (state_q == RESP) && !cancel_q && !bus.flush;
    // Freezes the PC from the request cycle until the word is delivered.
    assign bus.stall     = bus.cpu_req && !bus.cpu_valid;
    assign bus.cpu_inst  = cpu_inst_q;
    assign bus.cpu_adel  = cpu_adel_q;
    assign bus.sram_req  = sram_req_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_wr   = 1'b0;
    assign bus.sram_size = 2'b10;

endmodule

// File: tb/tb_ifetch_sram_bridge.sv
// ----------------------------------------------------------------------------
// tb_ifetch_sram_bridge
//   Drives the bridge as IF stage and instruction bus. A transaction-level
//   model (accept time, addr_ok time, response time) predicts every output on
//   every cycle; directed scenarios add literal expectations, then a random
//   phase exercises latencies, flushes, misaligned PCs and resets.
// ----------------------------------------------------------------------------
module tb_ifetch_sram_bridge;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    ifetch_sram_bridge_if bus ();

    ifetch_sram_bridge #(.MAP_EN(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Transaction model
    bit          m_busy, m_mis, m_cancel, m_adel;
    int          t_aok, t_resp;
    logic [31:0] m_paddr, m_inst;
    bit          last_valid;

    function automatic logic [31:0] phys(input logic [31:0] va);
        if (va[31:30] == 2'b10) return va & 32'h1FFF_FFFF;
        return va;
    endfunction

    function automatic bit exp_req();
        return m_busy && !m_mis && (t_aok < 0);
    endfunction

    function automatic bit data_phase();
        return m_busy && !m_mis && (t_aok >= 0) && (t_resp < 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_mis = 0; m_cancel = 0; m_adel = 0;
        t_aok = -1; t_resp = -1;
        m_paddr = 32'h0; m_inst = 32'h0;
    endtask

    task automatic drive(input bit req, input logic [31:0] addr, input bit fl,
                         input bit aok, input bit dok, input logic [31:0] rd);
        bus.cpu_req      = req;
        bus.cpu_addr     = addr;
        bus.flush        = fl;
        bus.sram_addr_ok = aok;
        bus.sram_data_ok = dok;
        bus.sram_rdata   = rd;
    endtask

    // Called just after a falling edge once inputs are applied.
    task automatic sample();
        bit resp_now, ev;
        #1;
        if (!resetn) model_reset();
        resp_now   = m_busy && (t_resp == cyc);
        ev         = resp_now && !m_cancel && !bus.flush;
        last_valid = ev;
        chk("sram_req",  32'(bus.sram_req),  32'(exp_req()));
        chk("sram_addr", bus.sram_addr,      m_paddr);
        chk("sram_wr",   32'(bus.sram_wr),   32'd0);
        chk("sram_size", 32'(bus.sram_size), 32'd2);
        chk("cpu_valid", 32'(bus.cpu_valid), 32'(ev));
        chk("stall",     32'(bus.stall),     32'(bus.cpu_req && !ev));
        chk("cpu_inst",  bus.cpu_inst,       m_inst);
        chk("cpu_adel",  32'(bus.cpu_adel),  32'(m_adel));
    endtask

    // Applies the inputs seen at the rising edge to the model.
    task automatic advance();
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else if (m_busy) begin
            if (t_resp == cyc) begin
                m_busy = 0; m_cancel = 0;
            end else begin
                if (bus.flush) m_cancel = 1;
                if (data_phase() && bus.sram_data_ok) begin
                    t_resp = cyc + 1; m_inst = bus.sram_rdata; m_adel = 0;
                end
                if (exp_req() && bus.sram_addr_ok) t_aok = cyc;
            end
        end else if (bus.cpu_req && !bus.flush) begin
            m_busy = 1; m_cancel = 0; t_aok = -1;
            if (bus.cpu_addr[1:0] != 2'b00) begin
                m_mis = 1; t_resp = cyc + 1; m_inst = 32'h0; m_adel = 1;
            end else begin
                m_mis = 0; t_resp = -1; m_paddr = phys(bus.cpu_addr);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 2))
            0:       a = 32'h8000_0000 | ($urandom() & 32'h1FFF_FFFF);
            1:       a = 32'hA000_0000 | ($urandom() & 32'h1FFF_FFFF);
            default: a = $urandom();
        endcase
        if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        bit          fl, aok, dok, prev_done, r_req;
        logic [31:0] r_addr;

        model_reset();
        resetn = 1'b0;
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        @(negedge clk);

        // Reset values
        sample();
        chk("rst_sram_req",  32'(bus.sram_req),  32'd0);
        chk("rst_sram_addr", bus.sram_addr,      32'h0);
        chk("rst_valid",     32'(bus.cpu_valid), 32'd0);
        chk("rst_stall0",    32'(bus.stall),     32'd0);
        bus.cpu_req = 1'b1;
        sample();
        chk("rst_stall1",    32'(bus.stall),     32'd1);
        advance();
        resetn = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        sample(); advance();

        // Zero-wait fetch of 0xBFC00000
        drive(1, 32'hBFC0_0000, 0, 0, 0, 32'h0);
        sample(); chk("zw_c0_stall", 32'(bus.stall), 1); chk("zw_c0_req", 32'(bus.sram_req), 0); advance();
        drive(1, 32'hBFC0_0000, 0, 1, 0, 32'h0);
        sample(); chk("zw_c1_req", 32'(bus.sram_req), 1); chk("zw_c1_addr", bus.sram_addr, 32'h1FC0_0000);
        chk("zw_c1_stall", 32'(bus.stall), 1); advance();
        drive(1, 32'hBFC0_0000, 0, 0, 1, 32'h3C1D_0001);
        sample(); chk("zw_c2_req", 32'(bus.sram_req), 0); chk("zw_c2_stall", 32'(bus.stall), 1); advance();
        drive(1, 32'hBFC0_0000, 0, 0, 0, 32'h0);
        sample(); chk("zw_c3_valid", 32'(bus.cpu_valid), 1); chk("zw_c3_inst", bus.cpu_inst, 32'h3C1D_0001);
        chk("zw_c3_adel", 32'(bus.cpu_adel), 0); chk("zw_c3_stall", 32'(bus.stall), 0); advance();
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        sample(); chk("zw_c4_valid", 32'(bus.cpu_valid), 0); advance();

        // Delayed addr_ok (4 waits) and data_ok (3 waits), addr 0x80001000
        drive(1, 32'h8000_1000, 0, 0, 0, 32'h0);
        sample(); advance();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h8000_1000, 0, i == 4, 0, 32'h0);
            sample(); chk("dl_req", 32'(bus.sram_req), 1); chk("dl_addr", bus.sram_addr, 32'h0000_1000); advance();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h8000_1000, 0, 0, i == 3, (i == 3) ? 32'hCAFE_F00D : 32'h0);
            sample(); chk("dl_req_low", 32'(bus.sram_req), 0); chk("dl_novalid", 32'(bus.cpu_valid), 0); advance();
        end
        drive(1, 32'h8000_1000, 0, 0, 0, 32'h0);
        sample(); chk("dl_valid", 32'(bus.cpu_valid), 1); chk("dl_inst", bus.cpu_inst, 32'hCAFE_F00D); advance();
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        sample(); chk("dl_valid_once", 32'(bus.cpu_valid), 0); advance();

        // Misaligned PC
        drive(1, 32'hBFC0_0002, 0, 0, 0, 32'h0);
        sample(); chk("ma_c0_req", 32'(bus.sram_req), 0); advance();
        sample(); chk("ma_valid", 32'(bus.cpu_valid), 1); chk("ma_adel", 32'(bus.cpu_adel), 1);
        chk("ma_inst", bus.cpu_inst, 32'h0); chk("ma_req", 32'(bus.sram_req), 0); advance();
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        sample(); advance();

        // Flush in DATA, redirect to 0xBFC00100
        drive(1, 32'hBFC0_0000, 0, 0, 0, 32'h0);         sample(); advance();
        drive(1, 32'hBFC0_0000, 0, 1, 0, 32'h0);         sample(); advance();
        drive(1, 32'hBFC0_0000, 1, 0, 0, 32'h0);         sample(); advance();
        drive(1, 32'hBFC0_0100, 0, 0, 1, 32'hDEAD_BEEF);
        sample(); chk("fd_stale_valid", 32'(bus.cpu_valid), 0); advance();
        drive(1, 32'hBFC0_0100, 0, 0, 0, 32'h0);
        sample(); chk("fd_resp_valid", 32'(bus.cpu_valid), 0); chk("fd_resp_stall", 32'(bus.stall), 1); advance();
        sample(); chk("fd_idle_req", 32'(bus.sram_req), 0); advance();
        drive(1, 32'hBFC0_0100, 0, 1, 0, 32'h0);
        sample(); chk("fd_req", 32'(bus.sram_req), 1); chk("fd_addr", bus.sram_addr, 32'h1FC0_0100); advance();
        drive(1, 32'hBFC0_0100, 0, 0, 1, 32'h1234_5678); sample(); advance();
        drive(1, 32'hBFC0_0100, 0, 0, 0, 32'h0);
        sample(); chk("fd_valid", 32'(bus.cpu_valid), 1); chk("fd_inst", bus.cpu_inst, 32'h1234_5678); advance();
        drive(0, 32'h0, 0, 0, 0, 32'h0);                 sample(); advance();

        // Flush in ADDR with addr_ok held low for 3 cycles
        drive(1, 32'h8000_0040, 0, 0, 0, 32'h0);         sample(); advance();
        drive(1, 32'h8000_0040, 1, 0, 0, 32'h0);
        sample(); chk("fa_req0", 32'(bus.sram_req), 1); advance();
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 0, 0, 0, 32'h0);
            sample(); chk("fa_req_held", 32'(bus.sram_req), 1); advance();
        end
        drive(0, 32'h0, 0, 1, 0, 32'h0);
        sample(); chk("fa_req_aok", 32'(bus.sram_req), 1); advance();
        drive(0, 32'h0, 0, 0, 1, 32'h1111_1111);
        sample(); chk("fa_req_off", 32'(bus.sram_req), 0); advance();
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        sample(); chk("fa_valid", 32'(bus.cpu_valid), 0); advance();
        sample(); chk("fa_valid_late", 32'(bus.cpu_valid), 0); advance();

        // Reset while in DATA, then a stray data_ok
        drive(1, 32'hBFC0_0000, 0, 0, 0, 32'h0);         sample(); advance();
        drive(1, 32'hBFC0_0000, 0, 1, 0, 32'h0);         sample(); advance();
        resetn = 1'b0;
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        sample(); chk("rm_req", 32'(bus.sram_req), 0); chk("rm_addr", bus.sram_addr, 32'h0);
        chk("rm_inst", bus.cpu_inst, 32'h0); chk("rm_valid", 32'(bus.cpu_valid), 0);
        chk("rm_adel", 32'(bus.cpu_adel), 0); advance();
        resetn = 1'b1;
        drive(0, 32'h0, 0, 0, 1, 32'hAAAA_5555);
        sample(); chk("rm_stray_valid", 32'(bus.cpu_valid), 0); advance();
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        sample(); chk("rm_after_valid", 32'(bus.cpu_valid), 0); chk("rm_after_inst", bus.cpu_inst, 32'h0);
        chk("rm_after_req", 32'(bus.sram_req), 0); advance();

        // Random traffic
        prev_done = 1'b1;
        r_req     = 1'b0;
        r_addr    = 32'h0;
        for (int n = 0; n < 4000; n++) begin
            resetn = ($urandom_range(0, 499) != 0);
            if (prev_done) begin
                r_req  = ($urandom_range(0, 9) < 7);
                r_addr = rand_addr();
            end
            fl  = ($urandom_range(0, 19) == 0);
            aok = exp_req()    ? ($urandom_range(0, 2) == 0) : 1'b0;
            dok = data_phase() ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
            drive(r_req, r_addr, fl, aok, dok, $urandom());
            sample();
            prev_done = last_valid || fl || !r_req || !resetn;
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
